uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter between NUM_REQ byte-stream requesters: GPS config sender, telemetry packer, debug port.
- Arbitrates round-robin at packet granularity. Once a requester wins, it keeps the UART until it sends a byte flagged last.
- Drives the UART's tx_data/tx_send/tx_busy interface, so requesters never touch the UART directly.

---
 rtl/uart_tx_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//
// Shares one UART transmitter between NUM_REQ byte-stream requesters (GPS
// config sender, telemetry packer, debug port). Arbitration is round-robin at
// packet granularity: once a requester wins, it keeps the UART until one of
// its bytes flagged last has been handed over and the UART has gone idle.
//
// Optional feature (compile-time macro UART_ARB_TIMEOUT_EN):
//   When defined, an owner that stalls for TIMEOUT_CYCLES cycles between bytes
//   of a packet is evicted and timeout_err pulses for one cycle. When not
//   defined, HOLD waits indefinitely and timeout_err is tied low.
//
// Parameters:
//   NUM_REQ         number of requesters (2..8)
//   TIMEOUT_CYCLES  inter-byte stall limit (only with UART_ARB_TIMEOUT_EN)
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   req_valid    requester i has a byte to send
//   req_data     byte for requester i in bits [8i+7:8i]
//   req_last     requester i's byte is the final byte of its packet
//   req_ready    one-cycle pulse: requester i's byte was accepted
//   grant        one-hot current owner, all-zero when idle
//   tx_data      byte to the UART (holds between sends)
//   tx_send      one-cycle send strobe to the UART
//   tx_busy      UART is transmitting
//   timeout_err  one-cycle pulse: owner stalled and was evicted

module uart_tx_arbiter #(
  parameter int NUM_REQ = 3
`ifdef UART_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic [7:0]           tx_data,
  output logic                 tx_send,
  input  logic                 tx_busy,
  output logic                 timeout_err
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    GUARD,
    DRAIN,
    HOLD
  } state_t;

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic               last_q;

  logic [PTR_W-1:0]   winner;
  logic               owner_valid;
  logic               load_en;
  logic [PTR_W-1:0]   load_idx;
  logic [NUM_REQ-1:0] load_onehot;
  logic [7:0]         sel_data;
  logic               sel_last;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0]   stall_cnt;
`endif

  // Round-robin pick: scan rr_ptr+1 upward with wrap. The loop runs from the
  // farthest candidate down to the nearest so the nearest valid one wins.
  always_comb begin
    logic [PTR_W:0] sum;
    winner = '0;
    sum    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_REQ)) begin
        sum = sum - (PTR_W+1)'(NUM_REQ);
      end
      if (req_valid[sum[PTR_W-1:0]]) begin
        winner = sum[PTR_W-1:0];
      end
    end
  end

  // rr_ptr doubles as the owner index while a packet is in progress.
  always_comb begin
    owner_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rr_ptr == PTR_W'(i)) begin
        owner_valid = req_valid[i];
      end
    end
  end

  // A byte is loaded from IDLE (after arbitration) or from HOLD (owner only).
  always_comb begin
    load_en  = 1'b0;
    load_idx = rr_ptr;
    if (state == IDLE) begin
      load_en  = (|req_valid) && !tx_busy;
      load_idx = winner;
    end else if (state == HOLD) begin
      load_en  = owner_valid && !tx_busy;
    end
  end

  always_comb begin
    sel_data    = 8'h00;
    sel_last    = 1'b0;
    load_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (load_idx == PTR_W'(i)) begin
        sel_data       = req_data[8*i +: 8];
        sel_last       = req_last[i];
        load_onehot[i] = 1'b1;
      end
    end
  end

  // Main FSM. GUARD is a fixed one-cycle gap after each send so that DRAIN
  // never sees the stale tx_busy=0 from before the UART reacted to tx_send.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= PTR_W'(NUM_REQ - 1);
      last_q    <= 1'b0;
      grant     <= '0;
      req_ready <= '0;
      tx_data   <= 8'h00;
      tx_send   <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      tx_send   <= 1'b0;
      req_ready <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      if (load_en) begin
        grant     <= load_onehot;
        req_ready <= load_onehot;
        tx_data   <= sel_data;
        tx_send   <= 1'b1;
        last_q    <= sel_last;
        rr_ptr    <= load_idx;
        state     <= GUARD;
`ifdef UART_ARB_TIMEOUT_EN
        stall_cnt <= '0;
`endif
      end else begin
        case (state)
          GUARD: state <= DRAIN;
          DRAIN: begin
            if (!tx_busy) begin
              if (last_q) begin
                grant <= '0;
                state <= IDLE;
              end else begin
                state <= HOLD;
              end
            end
          end
`ifdef UART_ARB_TIMEOUT_EN
          // Eviction leaves rr_ptr on the evicted owner so the others get
          // the next turn.
          HOLD: begin
            if (!owner_valid) begin
              if (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                grant       <= '0;
                timeout_err <= 1'b1;
                stall_cnt   <= '0;
                state       <= IDLE;
              end else begin
                stall_cnt <= stall_cnt + CNT_W'(1);
              end
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

`ifndef UART_ARB_TIMEOUT_EN
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter with NUM_REQ=3. A small UART model
// raises tx_busy one cycle after each tx_send and holds it for busy_len
// cycles. The timeout scenario is built only when UART_ARB_TIMEOUT_EN is
// defined (TIMEOUT_CYCLES=16).

module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  req_valid;
  logic [23:0] req_data;
  logic [2:0]  req_last;
  logic [2:0]  req_ready;
  logic [2:0]  grant;
  logic [7:0]  tx_data;
  logic        tx_send;
  logic        tx_busy;
  logic        timeout_err;

  int n_assert;
  int n_fail;
  int busy_len;
  int g;

  uart_tx_arbiter #(
    .NUM_REQ(3)
`ifdef UART_ARB_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .grant(grant),
    .tx_data(tx_data),
    .tx_send(tx_send),
    .tx_busy(tx_busy),
    .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // UART model: busy rises the cycle after tx_send, lasts busy_len cycles.
  initial begin
    bit pending;
    int remain;
    pending = 1'b0;
    remain  = 0;
    tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (pending) begin
        tx_busy = 1'b1;
        remain  = busy_len;
        pending = 1'b0;
      end else if (remain > 0) begin
        remain = remain - 1;
        if (remain == 0) tx_busy = 1'b0;
      end
      if (tx_send) pending = 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] v, input logic [23:0] d,
                               input logic [2:0] l);
    req_valid = v;
    req_data  = d;
    req_last  = l;
  endtask

  // Waits (sampling on negedges) for tx_send; returns cycles waited.
  task automatic wait_send(input int limit, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!tx_send && waited < limit);
    checkOutput("tx_send_seen", 32'(tx_send), 32'd1);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    busy_len = 10;
    rst      = 1'b1;
    applyStimulus(3'b000, 24'h0, 3'b000);

    // Reset state
    @(negedge clk);
    checkOutput("rst_grant", 32'(grant), 32'd0);
    checkOutput("rst_tx_send", 32'(tx_send), 32'd0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_tx_data", 32'(tx_data), 32'd0);
    checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Test 1: single requester, 3-byte packet, UART busy 10 cycles per byte
    $display("[TB] test 1: three-byte packet from req 0");
    applyStimulus(3'b001, 24'h000024, 3'b000);
    wait_send(4, g);
    checkOutput("t1_b0_latency", 32'(g), 32'd1);
    checkOutput("t1_b0_data", 32'(tx_data), 32'h24);
    checkOutput("t1_b0_grant", 32'(grant), 32'b001);
    checkOutput("t1_b0_ready", 32'(req_ready), 32'b001);
    applyStimulus(3'b001, 24'h000050, 3'b000);
    wait_send(20, g);
    checkOutput("t1_b1_gap", 32'(g), 32'd13);
    checkOutput("t1_b1_data", 32'(tx_data), 32'h50);
    checkOutput("t1_b1_grant", 32'(grant), 32'b001);
    checkOutput("t1_b1_ready", 32'(req_ready), 32'b001);
    applyStimulus(3'b001, 24'h00000A, 3'b001);
    wait_send(20, g);
    checkOutput("t1_b2_gap", 32'(g), 32'd13);
    checkOutput("t1_b2_data", 32'(tx_data), 32'h0A);
    applyStimulus(3'b000, 24'h0, 3'b000);
    repeat (11) @(negedge clk);
    checkOutput("t1_grant_drain", 32'(grant), 32'b001);
    checkOutput("t1_data_hold", 32'(tx_data), 32'h0A);
    @(negedge clk);
    checkOutput("t1_grant_release", 32'(grant), 32'b000);

    // Test 2: simultaneous single-byte packets after reset, then rr fairness
    $display("[TB] test 2: round-robin between single-byte packets");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    busy_len = 3;
    applyStimulus(3'b011, 24'h002211, 3'b011);
    wait_send(4, g);
    checkOutput("t2_a_data", 32'(tx_data), 32'h11);
    checkOutput("t2_a_grant", 32'(grant), 32'b001);
    checkOutput("t2_a_ready", 32'(req_ready), 32'b001);
    applyStimulus(3'b010, 24'h002211, 3'b011);
    wait_send(10, g);
    checkOutput("t2_b_gap", 32'(g), 32'd6);
    checkOutput("t2_b_data", 32'(tx_data), 32'h22);
    checkOutput("t2_b_grant", 32'(grant), 32'b010);
    checkOutput("t2_b_ready", 32'(req_ready), 32'b010);
    applyStimulus(3'b110, 24'h443300, 3'b110);
    wait_send(10, g);
    checkOutput("t2_c_data", 32'(tx_data), 32'h44);
    checkOutput("t2_c_grant", 32'(grant), 32'b100);
    applyStimulus(3'b010, 24'h443300, 3'b110);
    wait_send(10, g);
    checkOutput("t2_d_data", 32'(tx_data), 32'h33);
    checkOutput("t2_d_grant", 32'(grant), 32'b010);
    applyStimulus(3'b000, 24'h0, 3'b000);
    repeat (6) @(negedge clk);

    // Test 3: req 1 held off while req 0 sends a 4-byte packet
    $display("[TB] test 3: packet lock against a competing requester");
    applyStimulus(3'b001, 24'h0000A0, 3'b000);
    wait_send(4, g);
    checkOutput("t3_b0_data", 32'(tx_data), 32'hA0);
    applyStimulus(3'b011, 24'h0055A1, 3'b010);
    wait_send(10, g);
    checkOutput("t3_b1_gap", 32'(g), 32'd6);
    checkOutput("t3_b1_data", 32'(tx_data), 32'hA1);
    checkOutput("t3_b1_ready", 32'(req_ready), 32'b001);
    applyStimulus(3'b011, 24'h0055A2, 3'b010);
    wait_send(10, g);
    checkOutput("t3_b2_data", 32'(tx_data), 32'hA2);
    checkOutput("t3_b2_grant", 32'(grant), 32'b001);
    applyStimulus(3'b011, 24'h0055A3, 3'b011);
    wait_send(10, g);
    checkOutput("t3_b3_data", 32'(tx_data), 32'hA3);
    checkOutput("t3_b3_ready", 32'(req_ready), 32'b001);
    applyStimulus(3'b010, 24'h0055A3, 3'b011);
    wait_send(10, g);
    checkOutput("t3_r1_gap", 32'(g), 32'd6);
    checkOutput("t3_r1_data", 32'(tx_data), 32'h55);
    checkOutput("t3_r1_grant", 32'(grant), 32'b010);
    checkOutput("t3_r1_ready", 32'(req_ready), 32'b010);
    applyStimulus(3'b000, 24'h0, 3'b000);
    repeat (6) @(negedge clk);

    // Test 4: long UART busy, sends must wait for tx_busy to fall
    $display("[TB] test 4: 50-cycle UART busy");
    busy_len = 50;
    applyStimulus(3'b100, 24'hA50000, 3'b000);
    wait_send(4, g);
    checkOutput("t4_b0_data", 32'(tx_data), 32'hA5);
    applyStimulus(3'b100, 24'h5A0000, 3'b100);
    @(negedge clk);
    checkOutput("t4_send_pulse", 32'(tx_send), 32'd0);
    wait_send(70, g);
    checkOutput("t4_b1_gap", 32'(g + 1), 32'd53);
    checkOutput("t4_b1_busy", 32'(tx_busy), 32'd0);
    checkOutput("t4_b1_data", 32'(tx_data), 32'h5A);
    applyStimulus(3'b000, 24'h0, 3'b000);
    repeat (55) @(negedge clk);
    busy_len = 3;

    // Test 5: reset during byte 2 of a 3-byte packet
    $display("[TB] test 5: reset mid-packet");
    applyStimulus(3'b001, 24'h0000C1, 3'b000);
    wait_send(4, g);
    checkOutput("t5_b0_data", 32'(tx_data), 32'hC1);
    applyStimulus(3'b001, 24'h0000C2, 3'b000);
    wait_send(10, g);
    checkOutput("t5_b1_data", 32'(tx_data), 32'hC2);
    rst = 1'b1;
    #1;
    checkOutput("t5_rst_grant", 32'(grant), 32'd0);
    checkOutput("t5_rst_tx_send", 32'(tx_send), 32'd0);
    checkOutput("t5_rst_ready", 32'(req_ready), 32'd0);
    checkOutput("t5_rst_tx_data", 32'(tx_data), 32'd0);
    applyStimulus(3'b000, 24'h0, 3'b000);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    applyStimulus(3'b101, 24'h660065, 3'b101);
    wait_send(4, g);
    checkOutput("t5_a_latency", 32'(g), 32'd1);
    checkOutput("t5_a_data", 32'(tx_data), 32'h65);
    checkOutput("t5_a_grant", 32'(grant), 32'b001);
    applyStimulus(3'b100, 24'h660065, 3'b101);
    wait_send(10, g);
    checkOutput("t5_b_data", 32'(tx_data), 32'h66);
    checkOutput("t5_b_grant", 32'(grant), 32'b100);
    checkOutput("t5_b_ready", 32'(req_ready), 32'b100);
    applyStimulus(3'b000, 24'h0, 3'b000);
    repeat (6) @(negedge clk);

`ifdef UART_ARB_TIMEOUT_EN
    // Test 6: owner stalls after one non-last byte and gets evicted
    $display("[TB] test 6: stall timeout");
    applyStimulus(3'b011, 24'h008877, 3'b010);
    wait_send(4, g);
    checkOutput("t6_b0_data", 32'(tx_data), 32'h77);
    checkOutput("t6_b0_grant", 32'(grant), 32'b001);
    applyStimulus(3'b010, 24'h008877, 3'b010);
    repeat (20) @(negedge clk);
    checkOutput("t6_pre_err", 32'(timeout_err), 32'd0);
    checkOutput("t6_pre_grant", 32'(grant), 32'b001);
    @(negedge clk);
    checkOutput("t6_err", 32'(timeout_err), 32'd1);
    checkOutput("t6_evict_grant", 32'(grant), 32'b000);
    @(negedge clk);
    checkOutput("t6_err_pulse", 32'(timeout_err), 32'd0);
    checkOutput("t6_r1_send", 32'(tx_send), 32'd1);
    checkOutput("t6_r1_data", 32'(tx_data), 32'h88);
    checkOutput("t6_r1_grant", 32'(grant), 32'b010);
    applyStimulus(3'b000, 24'h0, 3'b000);
    repeat (6) @(negedge clk);
`endif

    checkOutput("end_idle_grant", 32'(grant), 32'd0);
    checkOutput("end_timeout_err", 32'(timeout_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
